mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Iterative multiply/divide unit for the EX stage.
- Sequences a shared 32-bit adder/shifter datapath through MULT/MULTU/DIV/DIVU.
- Sign-extends or zero-extends operands as the opcode requires.
- Owns the HI/LO registers.
- Raises o_busy so the hazard logic stalls any MFHI/MFLO or new mul/div until the result is committed.

Parameters:
- NB_DATA, 32, operand and HI/LO width.
- NB_OP, 3, opcode width.
- NB_CNT, 6, iteration counter width; must hold NB_DATA.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  launch request; sampled only when the unit is not busy.
- i_op  in  NB_OP  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MADD, 5=MADDU; 6-7 reserved.
- i_rs  in  NB_DATA  operand A (multiplicand/dividend).
- i_rt  in  NB_DATA  operand B (multiplier/divisor).
- i_hi_we  in  1  MTHI write enable.
- i_lo_we  in  1  MTLO write enable.
- i_wdata  in  NB_DATA  MTHI/MTLO data.
- i_flush  in  1  abort the in-flight operation.
- o_hi  out  NB_DATA  HI register.
- o_lo  out  NB_DATA  LO register.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle pulse when HI/LO are committed.

Behaviour:
Reset
- Async, active-low. Values: state=IDLE, o_hi=0, o_lo=0, o_busy=0, o_done=0, counter=0.
- Reset mid-operation discards all state immediately.

States
- IDLE, CALC, FIX, DONE.
- o_busy=1 exactly in CALC and FIX.
- o_done=1 exactly in DONE.

Transitions
- IDLE/DONE -> CALC: i_start=1 with a valid op.
  - Latch |rs| and |rt| for signed ops; latch raw operands for unsigned ops.
  - Latch result sign: rs[31]^rt[31] for the quotient/product; rs[31] for the remainder.
  - Clear counter.
- CALC: one iteration per cycle.
  - Multiply: shift-add.
  - Divide: restoring.
  - Uses a 33-bit add/sub.
  - Exit to FIX when counter==NB_DATA-1, i.e. after exactly 32 CALC cycles.
- FIX -> DONE: conditional two's-complement negation of the results, then commit to HI/LO.
  - Multiply: HI=product[63:32], LO=product[31:0].
  - Divide: LO=quotient, HI=remainder.
- DONE -> IDLE unless a new i_start is accepted.
- Latency: start sampled at edge T, o_done high and HI/LO valid in cycle T+34. Back-to-back throughput is one op per 34 cycles.

Corner cases
- Divide by zero: completes with normal latency; LO=32'hFFFF_FFFF, HI=rs.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0, no trap.
- i_start while busy: ignored, no queueing.
- Reserved op with i_start: ignored; stays in its current state.
- i_flush in CALC/FIX: next state IDLE, HI/LO unchanged, no o_done.
- i_flush in DONE: no effect; the commit has already happened.
- i_flush with i_start in the same cycle: flush wins, start dropped.
- MTHI/MTLO while idle/DONE: written at the edge.
- MTHI/MTLO while busy: dropped.
- MTHI/MTLO in the same cycle as an accepted i_start: the write applies, then the op overwrites at commit.

Width rules
- Product: 64-bit.
- Negation: 64-bit for products; 32-bit per half for divides.

Optional Feature:
Macro MDU_MADD_EN.
- Defined: ops 4/5 (MADD/MADDU) are valid. FIX adds the current {HI,LO} to the signed/unsigned 64-bit product, modulo 2^64, before commit. Latency is unchanged.
- Undefined: ops 4/5 are treated as reserved and ignored.

Decomposition:
- Package mdu_pkg holds:
  - op encodings MDU_MULT..MDU_MADDU;
  - state encoding IDLE/CALC/FIX/DONE;
  - NB_DATA default;
  - DIV0_LO constant 32'hFFFF_FFFF.
- One sub-module, mdu_datapath: 64-bit shift/accumulate registers, 33-bit adder, negate logic.
- mdu_ctrl keeps the FSM, counter, HI/LO and handshake.

Test Plan:
- MULT rs=0xFFFF_FFFE (-2), rt=3 -> o_done at T+34; HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; o_busy high for 33 cycles.
- MULTU rs=0xFFFF_FFFF, rt=0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001.
- DIV rs=-7, rt=2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). DIVU 100/0 -> LO=0xFFFF_FFFF, HI=100.
- Start MULT, assert i_flush at T+10 -> o_busy=0 at T+11; no o_done; HI/LO keep their prior values. i_start at T+5 is ignored.
- MTLO 0x1234 during CALC -> LO unchanged; MTHI 0xABCD in IDLE -> o_hi=0xABCD next cycle.
- MDU_MADD_EN: HI=0, LO=0xFFFF_FFFF, MADDU 1*1 -> HI=1, LO=0. Without the macro, op 5 gives no busy and no done.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int NB_DATA_DEF = 32;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MADD  = 3'd4,
        MDU_MADDU = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    localparam logic [NB_DATA_DEF-1:0] DIV0_LO = 32'hFFFF_FFFF;

    // Magnitude of a possibly-signed operand; unsigned ops pass through untouched.
    function automatic logic [NB_DATA_DEF-1:0] abs_val(input logic [NB_DATA_DEF-1:0] v,
                                                      input logic sgn);
        if (sgn && v[NB_DATA_DEF-1]) begin
            abs_val = ~v + {{(NB_DATA_DEF-1){1'b0}}, 1'b1};
        end else begin
            abs_val = v;
        end
    endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Shared 33-bit add/sub datapath: shift-add multiply, restoring divide,
// and the final sign fix-up of product or quotient/remainder.
module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic               neg_q,
    input  logic               neg_r,
    input  logic [NB_DATA-1:0] ld_lo,
    input  logic [NB_DATA-1:0] ld_opnd,
    output logic [NB_DATA-1:0] res_hi,
    output logic [NB_DATA-1:0] res_lo
);

    logic [NB_DATA-1:0]   acc_hi_r;
    logic [NB_DATA-1:0]   acc_lo_r;
    logic [NB_DATA-1:0]   opnd_r;
    logic [NB_DATA:0]     add_a_s;
    logic [NB_DATA:0]     add_s;
    logic [NB_DATA-1:0]   hi_nxt_s;
    logic [NB_DATA-1:0]   lo_nxt_s;
    logic [2*NB_DATA-1:0] prod_s;
    logic [2*NB_DATA-1:0] prod_neg_s;

    // One iteration: add/sub, then shift right (multiply) or left (divide).
    always_comb begin
        add_a_s  = is_div ? {acc_hi_r, acc_lo_r[NB_DATA-1]} : {1'b0, acc_hi_r};
        add_s    = is_div ? (add_a_s - {1'b0, opnd_r}) : (add_a_s + {1'b0, opnd_r});
        hi_nxt_s = acc_hi_r;
        lo_nxt_s = acc_lo_r;
        if (is_div) begin
            // Divisor fits under the shifted remainder when the difference is non-negative.
            if (!add_s[NB_DATA]) begin
                hi_nxt_s = add_s[NB_DATA-1:0];
                lo_nxt_s = {acc_lo_r[NB_DATA-2:0], 1'b1};
            end else begin
                hi_nxt_s = add_a_s[NB_DATA-1:0];
                lo_nxt_s = {acc_lo_r[NB_DATA-2:0], 1'b0};
            end
        end else begin
            if (acc_lo_r[0]) begin
                {hi_nxt_s, lo_nxt_s} = {add_s, acc_lo_r[NB_DATA-1:1]};
            end else begin
                {hi_nxt_s, lo_nxt_s} = {1'b0, acc_hi_r, acc_lo_r[NB_DATA-1:1]};
            end
        end
    end

    // Accumulator and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi_r <= {NB_DATA{1'b0}};
            acc_lo_r <= {NB_DATA{1'b0}};
            opnd_r   <= {NB_DATA{1'b0}};
        end else if (load) begin
            acc_hi_r <= {NB_DATA{1'b0}};
            acc_lo_r <= ld_lo;
            opnd_r   <= ld_opnd;
        end else if (step) begin
            acc_hi_r <= hi_nxt_s;
            acc_lo_r <= lo_nxt_s;
        end
    end

    // Sign fix-up: 64-bit negate for products, per-half negate for divides.
    always_comb begin
        prod_s     = {acc_hi_r, acc_lo_r};
        prod_neg_s = ~prod_s + {{(2*NB_DATA-1){1'b0}}, 1'b1};
        if (is_div) begin
            res_lo = neg_q ? (~acc_lo_r + {{(NB_DATA-1){1'b0}}, 1'b1}) : acc_lo_r;
            res_hi = neg_r ? (~acc_hi_r + {{(NB_DATA-1){1'b0}}, 1'b1}) : acc_hi_r;
        end else begin
            {res_hi, res_lo} = neg_q ? prod_neg_s : prod_s;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit control: FSM, iteration counter, HI/LO and handshake.
// Define MDU_MADD_EN to enable MADD/MADDU accumulate into {HI,LO}.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = 3,
    parameter int NB_CNT  = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_rs,
    input  logic [NB_DATA-1:0] i_rt,
    input  logic               i_hi_we,
    input  logic               i_lo_we,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic               i_flush,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo,
    output logic               o_busy,
    output logic               o_done
);

    mdu_state_e         state_r, next_state_s;
    logic [NB_CNT-1:0]  cnt_r;
    logic [NB_DATA-1:0] hi_r, lo_r, res_hi_s, res_lo_s, abs_a_s, abs_b_s;
    logic               op_valid_s, op_signed_s, op_div_s, op_madd_s;
    logic               idle_like_s, accept_s, busy_nxt_s, done_nxt_s;
    logic               busy_r, done_r, is_div_r, is_madd_r, neg_q_r, neg_r_r, div0_r;

    // Opcode decode; MADD/MADDU decode only when the accumulate feature is built in.
    always_comb begin
        op_valid_s  = 1'b0;
        op_signed_s = 1'b0;
        op_div_s    = 1'b0;
        op_madd_s   = 1'b0;
        case (i_op)
            NB_OP'(MDU_MULT):  begin op_valid_s = 1'b1; op_signed_s = 1'b1; end
            NB_OP'(MDU_MULTU): begin op_valid_s = 1'b1; end
            NB_OP'(MDU_DIV):   begin op_valid_s = 1'b1; op_signed_s = 1'b1; op_div_s = 1'b1; end
            NB_OP'(MDU_DIVU):  begin op_valid_s = 1'b1; op_div_s = 1'b1; end
`ifdef MDU_MADD_EN
            NB_OP'(MDU_MADD):  begin op_valid_s = 1'b1; op_signed_s = 1'b1; op_madd_s = 1'b1; end
            NB_OP'(MDU_MADDU): begin op_valid_s = 1'b1; op_madd_s = 1'b1; end
`endif
            default:           begin op_valid_s = 1'b0; end
        endcase
    end

    assign idle_like_s = (state_r == IDLE) || (state_r == DONE);
    assign accept_s    = i_start && op_valid_s && !i_flush && idle_like_s;
    assign abs_a_s     = abs_val(i_rs, op_signed_s);
    assign abs_b_s     = abs_val(i_rt, op_signed_s);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; flush aborts CALC/FIX and beats a same-cycle start.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = accept_s ? CALC : IDLE;
            CALC:    begin
                if (i_flush) begin
                    next_state_s = IDLE;
                end else if (cnt_r == NB_CNT'(NB_DATA-1)) begin
                    next_state_s = FIX;
                end else begin
                    next_state_s = CALC;
                end
            end
            FIX:     next_state_s = i_flush ? IDLE : DONE;
            DONE:    next_state_s = accept_s ? CALC : IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode from the next state so the flags register in step with it.
    always_comb begin
        busy_nxt_s = (next_state_s == CALC) || (next_state_s == FIX);
        done_nxt_s = (next_state_s == DONE);
    end

    // Registered handshake flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Iteration counter and per-operation context captured at launch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r     <= {NB_CNT{1'b0}};
            is_div_r  <= 1'b0;
            is_madd_r <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            div0_r    <= 1'b0;
        end else if (accept_s) begin
            cnt_r     <= {NB_CNT{1'b0}};
            is_div_r  <= op_div_s;
            is_madd_r <= op_madd_s;
            neg_q_r   <= op_signed_s && (i_rs[NB_DATA-1] ^ i_rt[NB_DATA-1]);
            neg_r_r   <= op_signed_s && i_rs[NB_DATA-1];
            div0_r    <= op_div_s && (i_rt == {NB_DATA{1'b0}});
        end else if (state_r == CALC) begin
            cnt_r <= cnt_r + NB_CNT'(1);
        end
    end

    // HI/LO: commit at the end of FIX, otherwise MTHI/MTLO only while not busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_r <= {NB_DATA{1'b0}};
            lo_r <= {NB_DATA{1'b0}};
        end else if ((state_r == FIX) && !i_flush) begin
            if (div0_r) begin
                hi_r <= res_hi_s;
                lo_r <= DIV0_LO;
            end
`ifdef MDU_MADD_EN
            else if (is_madd_r) begin
                {hi_r, lo_r} <= {res_hi_s, res_lo_s} + {hi_r, lo_r};
            end
`endif
            else begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end
        end else if (idle_like_s) begin
            if (i_hi_we) hi_r <= i_wdata;
            if (i_lo_we) lo_r <= i_wdata;
        end
    end

    mdu_datapath #(.NB_DATA(NB_DATA)) u_datapath (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .load    (accept_s),
        .step    (state_r == CALC),
        .is_div  (is_div_r),
        .neg_q   (neg_q_r),
        .neg_r   (neg_r_r),
        .ld_lo   (op_div_s ? abs_a_s : abs_b_s),
        .ld_opnd (op_div_s ? abs_b_s : abs_a_s),
        .res_hi  (res_hi_s),
        .res_lo  (res_lo_s)
    );

    assign o_hi   = hi_r;
    assign o_lo   = lo_r;
    assign o_busy = busy_r;
    assign o_done = done_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO and completion cycle are
// queued at launch and checked by an independent monitor on o_done.
module tb_mdu_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start = 1'b0;
    logic [2:0]  i_op = 3'd0;
    logic [31:0] i_rs = 32'd0, i_rt = 32'd0, i_wdata = 32'd0;
    logic        i_hi_we = 1'b0, i_lo_we = 1'b0, i_flush = 1'b0;
    logic [31:0] o_hi, o_lo;
    logic        o_busy, o_done;

    mdu_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
        .i_rs(i_rs), .i_rt(i_rt), .i_hi_we(i_hi_we), .i_lo_we(i_lo_we),
        .i_wdata(i_wdata), .i_flush(i_flush),
        .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] hi; logic [31:0] lo; int at; } exp_t;
    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit op_ok(input logic [2:0] op);
`ifdef MDU_MADD_EN
        return op <= 3'd5;
`else
        return op <= 3'd3;
`endif
    endfunction

    // Reference: plain 64-bit arithmetic, results as {HI,LO}.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] hilo);
        longint sa, sb;
        logic [63:0] q64, r64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return sa * sb;
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2, 3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 3'd2) begin q64 = sa / sb; r64 = sa % sb; end
                else begin q64 = {32'd0, a / b}; r64 = {32'd0, a % b}; end
                return {r64[31:0], q64[31:0]};
            end
            3'd4: return (sa * sb) + hilo;
            3'd5: return ({32'd0, a} * {32'd0, b}) + hilo;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every o_done must match the oldest queued expectation.
    always @(negedge i_clk) begin
        if (i_rst_n && o_done) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done actual=1 expected=0 (cyc %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("done_hi", o_hi, mon_e.hi);
                check("done_lo", o_lo, mon_e.lo);
                check("done_cycle", cyc, mon_e.at);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit mth, input bit mtl, input logic [31:0] wd);
        logic [63:0] r;
        i_start = 1'b1; i_op = op; i_rs = a; i_rt = b;
        i_hi_we = mth; i_lo_we = mtl; i_wdata = wd;
        if (mth) m_hi = wd;
        if (mtl) m_lo = wd;
        if (op_ok(op)) begin
            r = ref_result(op, a, b, {m_hi, m_lo});
            sbq.push_back('{hi: r[63:32], lo: r[31:0], at: cyc + 34});
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        tick();
        i_start = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0;
        if (!op_ok(op)) check("reserved_busy", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (o_done) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=0 expected=1 (cyc %0d)", cyc);
        end
    endtask

    // Launch an op; with noise, drop MT writes and stray starts into the busy window.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit noise);
        int t0 = cyc;
        bit mt = noise && ($urandom_range(0, 3) == 0);
        issue(op, a, b, mt, mt && ($urandom_range(0, 1) == 1), $urandom);
        if (noise) begin
            while (cyc < t0 + 28) begin
                if ($urandom_range(0, 3) == 0) begin
                    i_hi_we = 1'($urandom_range(0, 1));
                    i_lo_we = ~i_hi_we;
                    i_wdata = $urandom;
                end
                if (cyc == t0 + 15) begin
                    i_start = 1'b1; i_op = 3'($urandom_range(0, 5)); i_rs = pick(); i_rt = pick();
                end
                tick();
                i_start = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0;
            end
        end
        wait_done();
    endtask

    initial begin
        int t0, nbusy;
        logic [31:0] sh, sl;
        logic [2:0]  rop;

        i_rst_n = 1'b0;
        repeat (3) tick();
        check("rst_hi", o_hi, 32'd0);
        check("rst_lo", o_lo, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        i_rst_n = 1'b1;
        tick();

        // MTHI in IDLE
        i_hi_we = 1'b1; i_wdata = 32'h0000_ABCD; tick(); i_hi_we = 1'b0;
        m_hi = 32'h0000_ABCD;
        check("mthi_idle", o_hi, 32'h0000_ABCD);

        // MULT -2*3, counting busy cycles
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 32'd0);
        nbusy = 0;
        for (int k = 0; k < 60 && !o_done; k++) begin
            if (o_busy) nbusy++;
            tick();
        end
        check("mult_busy_cycles", nbusy, 32'd33);
        check("mult_hi", o_hi, 32'hFFFF_FFFF);
        check("mult_lo", o_lo, 32'hFFFF_FFFA);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_hi", o_hi, 32'hFFFF_FFFE);
        check("multu_lo", o_lo, 32'h0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lo", o_lo, 32'hFFFF_FFFD);
        check("div_hi", o_hi, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd100, 32'd0, 1'b0);
        check("divu0_lo", o_lo, 32'hFFFF_FFFF);
        check("divu0_hi", o_hi, 32'd100);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("divovf_lo", o_lo, 32'h8000_0000);
        check("divovf_hi", o_hi, 32'd0);
        run_op(3'd2, 32'h8000_0005, 32'd0, 1'b0);
        tick();

        // Flush mid-CALC, with a dropped MTLO and a dropped start
        sh = m_hi; sl = m_lo; t0 = cyc;
        issue(3'd0, pick(), pick(), 1'b0, 1'b0, 32'd0);
        void'(sbq.pop_back());
        m_hi = sh; m_lo = sl;
        while (cyc < t0 + 3) tick();
        i_lo_we = 1'b1; i_wdata = 32'h0000_1234; tick(); i_lo_we = 1'b0;
        check("mtlo_busy", o_lo, m_lo);
        while (cyc < t0 + 5) tick();
        i_start = 1'b1; i_op = 3'd1; i_rs = 32'd7; i_rt = 32'd9; tick(); i_start = 1'b0;
        while (cyc < t0 + 10) tick();
        check("busy_pre_flush", {31'd0, o_busy}, 32'd1);
        i_flush = 1'b1; tick(); i_flush = 1'b0;
        check("busy_post_flush", {31'd0, o_busy}, 32'd0);
        repeat (40) tick();
        check("flush_hi", o_hi, m_hi);
        check("flush_lo", o_lo, m_lo);

        // Flush while in DONE is harmless; flush beats a same-cycle start
        run_op(3'd3, pick(), pick(), 1'b0);
        i_flush = 1'b1; tick(); i_flush = 1'b0;
        check("flush_done_hi", o_hi, m_hi);
        check("flush_done_lo", o_lo, m_lo);
        i_flush = 1'b1; i_start = 1'b1; i_op = 3'd0; tick();
        i_flush = 1'b0; i_start = 1'b0;
        check("flush_start_busy", {31'd0, o_busy}, 32'd0);
        repeat (40) tick();

        // Accumulate ops
        i_hi_we = 1'b1; i_wdata = 32'd0; tick(); i_hi_we = 1'b0;
        i_lo_we = 1'b1; i_wdata = 32'hFFFF_FFFF; tick(); i_lo_we = 1'b0;
        m_hi = 32'd0; m_lo = 32'hFFFF_FFFF;
`ifdef MDU_MADD_EN
        run_op(3'd5, 32'd1, 32'd1, 1'b0);
        check("maddu_hi", o_hi, 32'd1);
        check("maddu_lo", o_lo, 32'd0);
`else
        issue(3'd5, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0);
        repeat (40) tick();
        check("maddu_off_lo", o_lo, 32'hFFFF_FFFF);
`endif
        tick();

        // Randomized traffic
        for (int n = 0; n < 50; n++) begin
            rop = 3'($urandom_range(0, 7));
            if (op_ok(rop)) begin
                run_op(rop, pick(), pick(), 1'b1);
            end else begin
                tick();
                issue(rop, pick(), pick(), 1'b0, ($urandom_range(0, 1) == 1), $urandom);
            end
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
        end
        repeat (40) tick();
        check("final_hi", o_hi, m_hi);
        check("final_lo", o_lo, m_lo);

        // Asynchronous reset mid-operation
        issue(3'd0, pick(), pick(), 1'b0, 1'b0, 32'd0);
        repeat (10) tick();
        i_rst_n = 1'b0;
        #1;
        sbq.delete();
        m_hi = 32'd0; m_lo = 32'd0;
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        check("midrst_hi", o_hi, 32'd0);
        check("midrst_lo", o_lo, 32'd0);
        tick();
        i_rst_n = 1'b1;
        repeat (40) tick();

        check("pending_ops", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
